// File: rtl/sw_oport_arb_pkg.sv
// Shared constants for the packet switch output-port arbiter.
// Holds the flit type codes and the arbiter state encoding.
package sw_oport_arb_pkg;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10
  } flit_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_XFER  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sw_oport_arb_if.sv
// Handshake bundle between the input-side FIFO state machines and one output-port arbiter.
// The slave modport is the arbiter; the master modport is the input side.
interface sw_oport_arb_if #(
  parameter int unsigned NIN = 4
);
  localparam int unsigned SW = $clog2(NIN);

  logic [NIN-1:0]   req;
  logic [NIN-1:0]   empty;
  logic [2*NIN-1:0] pout;
  logic [NIN-1:0]   re;
  logic [NIN-1:0]   ack;
  logic [SW-1:0]    sel;
  logic             ovalid;
  logic             busy;
  logic             err;

  modport master (
    output req, empty, pout, re,
    input  ack, sel, ovalid, busy, err
  );

  modport slave (
    input  req, empty, pout, re,
    output ack, sel, ovalid, busy, err
  );

endinterface

// File: rtl/sw_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NIN.
module sw_rr_pick #(
  parameter int unsigned NIN = 4
) (
  input  logic [NIN-1:0]         req,
  input  logic [$clog2(NIN)-1:0] ptr,
  output logic                   any,
  output logic [$clog2(NIN)-1:0] winner
);

  localparam int unsigned PW    = $clog2(NIN);
  localparam logic [PW:0] NIN_W = (PW+1)'(NIN);

  logic [NIN-1:0] rot;
  logic [PW-1:0]  off;
  logic           found;
  logic [PW:0]    sum;

  always_comb begin
    // Rotating the doubled vector puts req[ptr] at bit 0, so the lowest set bit is the winner offset.
    rot   = NIN'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (rot[i] && !found) begin
        off   = PW'(i);
        found = 1'b1;
      end
    end
    any    = |req;
    sum    = {1'b0, ptr} + {1'b0, off};
    winner = (sum >= NIN_W) ? PW'(sum - NIN_W) : PW'(sum);
  end

endmodule

// File: rtl/sw_oport_arb.sv
// Output-port arbiter/sequencer: round-robin grant, owner steering until TAIL,
// and a watchdog that force-releases packets longer than MAXLEN flits.
module sw_oport_arb
  import sw_oport_arb_pkg::*;
#(
  parameter int unsigned NIN    = 4,
  parameter int unsigned MAXLEN = 16
) (
  input  logic          clk,
  input  logic          rst,
  sw_oport_arb_if.slave bus
);

  localparam int unsigned PW   = $clog2(NIN);
  localparam int unsigned CW   = $clog2(MAXLEN + 1);
  localparam logic [PW-1:0] LAST = PW'(NIN - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXLEN);

  arb_state_e     state, state_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [PW-1:0]  owner, owner_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic           any;
  logic [PW-1:0]  winner;
  logic           own_re, own_empty, own_tail;
  logic [NIN-1:0] ack_v;
  logic           busy_v, err_v;

  sw_rr_pick #(.NIN(NIN)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign own_re    = bus.re[owner];
  assign own_empty = bus.empty[owner];
  assign own_tail  = (bus.pout[{owner, 1'b0} +: 2] == FLIT_TAIL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    ack_v     = '0;
    busy_v    = NEGATE;
    err_v     = NEGATE;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          owner_nxt = winner;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        ack_v[owner] = ASSERT;
        busy_v       = ASSERT;
        ptr_nxt      = (owner == LAST) ? '0 : owner + 1'b1;
        cnt_nxt      = CW'(1);
        state_nxt    = (own_re && own_tail) ? ARB_IDLE : ARB_XFER;
      end
      ARB_XFER: begin
        busy_v = ASSERT;
        if (own_re && !own_empty && cnt != CMAX) cnt_nxt = cnt + 1'b1;
        // TAIL wins over the watchdog when both land in the same cycle.
        if (own_re && own_tail) begin
          state_nxt = ARB_IDLE;
        end else if (cnt == CMAX) begin
          err_v     = ASSERT;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.ack    = ack_v;
  assign bus.busy   = busy_v;
  assign bus.err    = err_v;
  assign bus.sel    = owner;
  assign bus.ovalid = busy_v && own_re && !own_empty;

endmodule
